// File: rtl/machine_seq_detect.sv
// Serial N-bit pattern detector: registered match pulse, prefix-match state, saturating match count.
// Outputs update on the edge that consumes a bit (zero extra latency); no backpressure, bits are taken whenever valid=1.
module machine_seq_detect #(
    parameter int           N             = 4,
    parameter int           CNT_W         = 8,
    parameter logic [N-1:0] RESET_PATTERN = 4'b1011
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     x,
    input  logic                     valid,
    input  logic                     overlap,
    input  logic                     load,
    input  logic [N-1:0]             pattern_in,
    output logic                     F,
    output logic [$clog2(N+1)-1:0]   S,
    output logic [CNT_W-1:0]         count,
    output logic                     sat
);

    localparam int               SW      = $clog2(N+1);
    localparam logic [SW-1:0]    FULL    = SW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     pat_q, pat_d;
    logic [N-1:0]     hist_q, hist_d;
    logic [SW-1:0]    len_q, len_d;
    logic             f_q, f_d;
    logic [SW-1:0]    s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             hit;

    // Longest suffix of the history (newest bit at bit 0) that equals a prefix of the pattern.
    function automatic logic [SW-1:0] prefix_len(input logic [N-1:0] h,
                                                 input logic [SW-1:0] len,
                                                 input logic [N-1:0] p);
        logic [SW-1:0] best;
        logic [N-1:0]  mask;
        best = '0;
        for (int k = 1; k <= N; k++) begin
            mask = N'((1 << k) - 1);
            if ((SW'(k) <= len) && (((h ^ (p >> (N - k))) & mask) == '0)) begin
                best = SW'(k);
            end
        end
        return best;
    endfunction

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        f_d    = 1'b0;
        hit    = 1'b0;
        if (load) begin
            pat_d  = pattern_in;
            hist_d = '0;
            len_d  = '0;
        end else if (valid) begin
            hist_d = {hist_q[N-2:0], x};
            len_d  = (len_q == FULL) ? FULL : len_q + 1'b1;
            hit    = (len_d == FULL) && (hist_d == pat_q);
            if (hit) begin
                f_d = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Non-overlapping mode starts the next match from scratch.
                if (!overlap) begin
                    hist_d = '0;
                    len_d  = '0;
                end
            end
        end
        s_d   = prefix_len(hist_d, len_d, pat_d);
        sat_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pat_q  <= RESET_PATTERN;
            hist_q <= '0;
            len_q  <= '0;
            f_q    <= 1'b0;
            s_q    <= '0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            len_q  <= len_d;
            f_q    <= f_d;
            s_q    <= s_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign F     = f_q;
    assign S     = s_q;
    assign count = cnt_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_machine_seq_detect.sv
// Bench for machine_seq_detect: two instances (8-bit and 2-bit counters) share stimulus and a queue-based model.
module tb_machine_seq_detect;
    localparam int N = 4;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESET, x, valid, overlap, load;
    logic [3:0] pattern_in;
    logic       F,  sat;
    logic [2:0] S;
    logic [7:0] count;
    logic       F2, sat2;
    logic [2:0] S2;
    logic [1:0] count2;

    machine_seq_detect #(.N(4), .CNT_W(8), .RESET_PATTERN(4'b1011)) u_dut (
        .CLK(CLK), .RESET(RESET), .x(x), .valid(valid), .overlap(overlap), .load(load),
        .pattern_in(pattern_in), .F(F), .S(S), .count(count), .sat(sat));

    machine_seq_detect #(.N(4), .CNT_W(2), .RESET_PATTERN(4'b1011)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .x(x), .valid(valid), .overlap(overlap), .load(load),
        .pattern_in(pattern_in), .F(F2), .S(S2), .count(count2), .sat(sat2));

    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 0;

    // Reference model: bit history as a queue, oldest first.
    bit         hist[$];
    logic [3:0] m_pat;
    logic       m_F;
    int         m_c8, m_c2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_s();
        int n;
        bit ok;
        n = hist.size();
        for (int k = n; k >= 1; k--) begin
            ok = 1;
            for (int i = 0; i < k; i++) begin
                if (hist[n-k+i] != m_pat[N-1-i]) ok = 0;
            end
            if (ok) return k;
        end
        return 0;
    endfunction

    function automatic bit model_full_match();
        if (hist.size() != N) return 0;
        for (int i = 0; i < N; i++) begin
            if (hist[i] != m_pat[N-1-i]) return 0;
        end
        return 1;
    endfunction

    task automatic model_update(input logic r, input logic ld, input logic [3:0] pin,
                                input logic v, input logic xb, input logic ov);
        m_F = 0;
        if (!r) begin
            m_pat = 4'b1011;
            hist.delete();
            m_c8 = 0;
            m_c2 = 0;
            chk_en = 1;
        end else if (ld) begin
            m_pat = pin;
            hist.delete();
        end else if (v) begin
            hist.push_back(xb);
            if (hist.size() > N) void'(hist.pop_front());
            if (model_full_match()) begin
                m_F = 1;
                m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
                m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
                if (!ov) hist.delete();
            end
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("F",      F,      m_F);
            chk("S",      S,      model_s());
            chk("count",  count,  m_c8);
            chk("sat",    sat,    m_c8 == 255);
            chk("F2",     F2,     m_F);
            chk("S2",     S2,     model_s());
            chk("count2", count2, m_c2);
            chk("sat2",   sat2,   m_c2 == 3);
        end
    end

    task automatic step(input logic r, input logic ld, input logic [3:0] pin,
                        input logic v, input logic xb, input logic ov);
        RESET = r; load = ld; pattern_in = pin; valid = v; x = xb; overlap = ov;
        @(posedge CLK);
        model_update(r, ld, pin, v, xb, ov);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bit_in(input logic xb, input logic ov);
        step(1'b1, 1'b0, 4'b0000, 1'b1, xb, ov);
    endtask

    task automatic idle(input logic xb);
        step(1'b1, 1'b0, 4'b0000, 1'b0, xb, 1'b0);
    endtask

    logic [6:0] stream   = 7'b1011011;
    int exp_s_ov[7]      = '{1, 2, 3, 4, 2, 3, 4};
    int exp_f_ov[7]      = '{0, 0, 0, 1, 0, 0, 1};
    int exp_s_no[7]      = '{1, 2, 3, 0, 0, 1, 1};
    int exp_f_no[7]      = '{0, 0, 0, 1, 0, 0, 0};
    logic [3:0] pat0110  = 4'b0110;
    logic [3:0] pat1011  = 4'b1011;
    int exp_s_ld[4]      = '{1, 2, 3, 4};
    logic tog;

    initial begin
        RESET = 0; x = 0; valid = 0; overlap = 0; load = 0; pattern_in = '0;

        do_reset();
        do_reset();
        idle(1'b1);
        chk("rst_F", F, 0);
        chk("rst_S", S, 0);
        chk("rst_count", count, 0);
        chk("rst_sat", sat, 0);

        for (int i = 0; i < 7; i++) begin
            bit_in(stream[6-i], 1'b1);
            chk("ov_S", S, exp_s_ov[i]);
            chk("ov_F", F, exp_f_ov[i]);
        end
        chk("ov_count", count, 2);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            bit_in(stream[6-i], 1'b0);
            chk("nov_S", S, exp_s_no[i]);
            chk("nov_F", F, exp_f_no[i]);
        end
        chk("nov_count", count, 1);

        do_reset();
        tog = 0;
        for (int i = 0; i < 7; i++) begin
            bit_in(stream[6-i], 1'b1);
            chk("gap_S", S, exp_s_ov[i]);
            chk("gap_F", F, exp_f_ov[i]);
            for (int j = 0; j < 3; j++) begin
                idle(tog);
                tog = ~tog;
                chk("gap_idle_F", F, 0);
                chk("gap_idle_S", S, exp_s_ov[i]);
            end
        end
        chk("gap_count", count, 2);

        bit_in(1'b0, 1'b1);
        bit_in(1'b1, 1'b1);
        chk("pre_load_S", S, 3);
        step(1'b1, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b1);
        chk("load_S", S, 0);
        chk("load_F", F, 0);
        chk("load_count", count, 2);
        for (int i = 0; i < 4; i++) begin
            bit_in(pat0110[3-i], 1'b1);
            chk("ld_S", S, exp_s_ld[i]);
            chk("ld_F", F, i == 3);
        end
        chk("ld_count", count, 3);

        do_reset();
        step(1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            bit_in(1'b1, 1'b1);
            chk("ones_F2", F2, i >= 3);
        end
        chk("ones_count2", count2, 3);
        chk("ones_sat2", sat2, 1);
        chk("ones_count", count, 5);

        do_reset();
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b0);
        chk("mid_S", S, 3);
        do_reset();
        chk("mid_rst_S", S, 0);
        chk("mid_rst_count", count, 0);
        for (int i = 0; i < 4; i++) bit_in(pat1011[3-i], 1'b0);
        chk("mid_rst_pat_F", F, 1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0, $urandom_range(0, 39) == 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(negedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
